// File: rtl/control_unit.sv
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired Moore sequencer that fetches, decodes and executes
//                instructions by driving the datapath control strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  opcode,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_OR   = 5'b01011;
    localparam logic [4:0] c_OP_AND  = 5'b01010;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_ANDI = 5'b01101;
    localparam logic [4:0] c_OP_ORI  = 5'b01110;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_NEG  = 5'b10001;
    localparam logic [4:0] c_OP_NOT  = 5'b10010;
    localparam logic [4:0] c_OP_MFHI = 5'b10011;
    localparam logic [4:0] c_OP_MFLO = 5'b10100;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    state_t     state_q;
    state_t     state_d;
    state_t     w_next_instr;

    logic [4:0] w_op;
    logic       w_is_rr;
    logic       w_is_imm;
    logic       w_is_unary;
    logic       w_is_muldiv;
    logic       w_is_mfhi;
    logic       w_is_mflo;
    logic       w_is_halt;
    logic [4:0] w_imm_alu;
    logic       w_unused;

    assign w_op        = IR[31:27];
    assign w_unused    = ^IR[26:0];
    assign w_is_rr     = (w_op >= c_OP_ADD) && (w_op <= c_OP_OR);
    assign w_is_imm    = (w_op >= c_OP_ADDI) && (w_op <= c_OP_ORI);
    assign w_is_unary  = (w_op == c_OP_NEG) || (w_op == c_OP_NOT);
    assign w_is_muldiv = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
    assign w_is_mfhi   = (w_op == c_OP_MFHI);
    assign w_is_mflo   = (w_op == c_OP_MFLO);
    assign w_is_halt   = (w_op == c_OP_HALT);
    assign w_imm_alu   = (w_op == c_OP_ANDI) ? c_OP_AND :
                         (w_op == c_OP_ORI)  ? c_OP_OR  : c_OP_ADD;

    // Stop only matters on the edge that closes an instruction.
    assign w_next_instr = Stop ? S_HALT : T0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        opcode   = 5'b00000;
        Run      = (state_q != S_RESET) && (state_q != S_HALT);

        case (state_q)
            S_RESET: state_d = T0;
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = T1;
            end
            T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = T2;
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (w_is_muldiv) begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    Yin     = 1'b1;
                    state_d = T4;
                end else if (w_is_rr || w_is_imm || w_is_unary) begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    Yin     = 1'b1;
                    state_d = T4;
                end else if (w_is_mfhi || w_is_mflo) begin
                    HIout   = w_is_mfhi;
                    LOout   = w_is_mflo;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    state_d = w_next_instr;
                end else if (w_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = w_next_instr;
                end
            end
            T4: begin
                Zin     = 1'b1;
                state_d = T5;
                if (w_is_imm) begin
                    Cout   = 1'b1;
                    opcode = w_imm_alu;
                end else if (w_is_rr) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    opcode = w_op;
                end else begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    opcode = w_op;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    state_d = w_next_instr;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = w_next_instr;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit against an
//                instruction-level strobe-sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        Clock;
    logic        Reset;
    logic        Stop;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  opcode;
    logic        Run;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .opcode(opcode), .Run(Run)
    );

    // Observed outputs packed as {opcode, Run, strobes[20:0]}
    logic [26:0] act;
    assign act = {opcode, Run, Rout, Rin, Grc, Grb, Gra, Cout, LOout, HIout,
                  LOin, HIin, Zlowout, Zhighout, Zin, Yin, IRin, MDRout,
                  MDRin, Read, IncPC, MARin, PCout};

    localparam logic [26:0] M_PCOUT  = 27'd1 << 0;
    localparam logic [26:0] M_MARIN  = 27'd1 << 1;
    localparam logic [26:0] M_INCPC  = 27'd1 << 2;
    localparam logic [26:0] M_READ   = 27'd1 << 3;
    localparam logic [26:0] M_MDRIN  = 27'd1 << 4;
    localparam logic [26:0] M_MDROUT = 27'd1 << 5;
    localparam logic [26:0] M_IRIN   = 27'd1 << 6;
    localparam logic [26:0] M_YIN    = 27'd1 << 7;
    localparam logic [26:0] M_ZIN    = 27'd1 << 8;
    localparam logic [26:0] M_ZHI    = 27'd1 << 9;
    localparam logic [26:0] M_ZLO    = 27'd1 << 10;
    localparam logic [26:0] M_HIIN   = 27'd1 << 11;
    localparam logic [26:0] M_LOIN   = 27'd1 << 12;
    localparam logic [26:0] M_HIOUT  = 27'd1 << 13;
    localparam logic [26:0] M_LOOUT  = 27'd1 << 14;
    localparam logic [26:0] M_COUT   = 27'd1 << 15;
    localparam logic [26:0] M_GRA    = 27'd1 << 16;
    localparam logic [26:0] M_GRB    = 27'd1 << 17;
    localparam logic [26:0] M_GRC    = 27'd1 << 18;
    localparam logic [26:0] M_RIN    = 27'd1 << 19;
    localparam logic [26:0] M_ROUT   = 27'd1 << 20;
    localparam logic [26:0] M_RUN    = 27'd1 << 21;
    localparam logic [26:0] M_FETCH0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC;

    int n_vec = 0;
    int n_err = 0;
    logic [26:0] exp_q[$];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [26:0] alu_sel(input logic [4:0] op);
        return 27'(op) << 22;
    endfunction

    // Reference: per-cycle strobe list of one instruction, from T0 up to its last state
    task automatic build_seq(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        exp_q.delete();
        exp_q.push_back(M_FETCH0);
        exp_q.push_back(M_RUN | M_READ | M_MDRIN);
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu_sel(op));
            exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_COUT | M_ZIN |
                            alu_sel(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd10 : 5'd11)));
            exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZIN | alu_sel(op));
            exp_q.push_back(M_RUN | M_ZLO | M_GRA | M_RIN);
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZIN | alu_sel(op));
            exp_q.push_back(M_RUN | M_ZLO | M_LOIN);
            exp_q.push_back(M_RUN | M_ZHI | M_HIIN);
        end else if (op == 5'd19) begin
            exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
        end else if (op == 5'd20) begin
            exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
        end else begin
            exp_q.push_back(M_RUN);
        end
    endtask

    // Entered #1 after the edge into T0; leaves #1 after the following boundary edge
    task automatic run_instr(input logic [31:0] ir, input bit stop_end,
                             input int pulse_at, input string name, output bit halted);
        int len;
        logic [26:0] want;
        IR = ir;
        build_seq(ir);
        len = exp_q.size();
        for (int i = 0; i < len; i++) begin
            if (i == pulse_at) Stop = 1'b1;
            else if (i == pulse_at + 1) Stop = 1'b0;
            if (i == len - 1) Stop = stop_end;
            n_vec++;
            if (act !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s ir=%h cycle %0d: got %h want %h", name, ir, i, act, exp_q[i]);
            end
            step();
        end
        halted = stop_end || (ir[31:27] == 5'd27);
        want = halted ? 27'd0 : M_FETCH0;
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s ir=%h boundary: got %h want %h", name, ir, act, want);
        end
        Stop = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if (act !== 27'd0) begin
            n_err++;
            $display("FAIL %s async reset: got %h want 0", name, act);
        end
        step();
        n_vec++;
        if (act !== 27'd0) begin
            n_err++;
            $display("FAIL %s reset held: got %h want 0", name, act);
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic measure_latency(input logic [31:0] ir, input int lat, input string name);
        int cnt;
        IR = ir;
        step();
        cnt = 1;
        while (PCout !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_vec++;
        if (cnt != lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, cnt, lat);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Stop  = 1'b0;
        IR    = 32'd0;
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if (act !== 27'd0) begin n_err++; $display("FAIL reset_async: got %h want 0", act); end
        step();
        n_vec++;
        if (act !== 27'd0) begin n_err++; $display("FAIL reset_held: got %h want 0", act); end
        Reset = 1'b0;
        step();
        n_vec++;
        if (act !== M_FETCH0) begin n_err++; $display("FAIL reset_T0: got %h want %h", act, M_FETCH0); end
        step();
        n_vec++;
        if (act !== (M_RUN | M_READ | M_MDRIN)) begin
            n_err++; $display("FAIL reset_T1: got %h want %h", act, M_RUN | M_READ | M_MDRIN);
        end
        step();
        n_vec++;
        if (act !== (M_RUN | M_MDROUT | M_IRIN)) begin
            n_err++; $display("FAIL reset_T2: got %h want %h", act, M_RUN | M_MDROUT | M_IRIN);
        end
        // Reset in the middle of an instruction restarts at T0
        do_reset("reset_mid");
        n_vec++;
        if (act !== M_FETCH0) begin n_err++; $display("FAIL reset_restart: got %h want %h", act, M_FETCH0); end
    endtask

    task automatic test_add();
        bit h;
        run_instr(32'h18918000, 1'b0, -1, "add", h);
        measure_latency(32'h18918000, 6, "add");
    endtask

    task automatic test_addi();
        bit h;
        run_instr(32'h61180005, 1'b0, -1, "addi", h);
    endtask

    task automatic test_mul();
        bit h;
        run_instr(32'h79180000, 1'b0, -1, "mul", h);
        measure_latency(32'h79180000, 7, "mul");
        measure_latency(32'hD0000000, 4, "nop");
    endtask

    task automatic test_stop_pulse();
        bit h;
        // Short Stop pulse that is gone before the boundary edge
        run_instr(32'hD0000000, 1'b0, 1, "stop_pulse", h);
    endtask

    task automatic test_stop_nop();
        IR = 32'hD0000000;
        n_vec++;
        if (act !== M_FETCH0) begin n_err++; $display("FAIL stop_nop T0: got %h want %h", act, M_FETCH0); end
        step();
        Stop = 1'b1;
        step();
        step();
        n_vec++;
        if (act !== M_RUN) begin n_err++; $display("FAIL stop_nop T3: got %h want %h", act, M_RUN); end
        step();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (act !== 27'd0) begin n_err++; $display("FAIL stop_nop halted %0d: got %h want 0", k, act); end
            step();
        end
        Stop = 1'b0;
        do_reset("stop_nop");
    endtask

    task automatic test_halt();
        bit h;
        run_instr(32'hD8000000, 1'b0, -1, "halt", h);
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (act !== 27'd0) begin n_err++; $display("FAIL halt_absorb %0d: got %h want 0", k, act); end
        end
        do_reset("halt");
        n_vec++;
        if (act !== M_FETCH0) begin n_err++; $display("FAIL halt_resume: got %h want %h", act, M_FETCH0); end
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        logic [31:0] ir;
        logic [4:0]  op;
        bit          se;
        bit          h;
        int          pa;
        for (int n = 0; n < 80; n++) begin
            rnd = $urandom();
            op  = 5'($urandom_range(0, 31));
            ir  = {op, rnd[26:0]};
            build_seq(ir);
            se = ($urandom_range(0, 9) == 0);
            pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 3)) : -1;
            run_instr(ir, se, pa, "random", h);
            if (h) do_reset("random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_mul();
        test_stop_pulse();
        test_stop_nop();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
